// File: rtl/riscv_pkg.sv
// Shared core definitions: datapath width, register addressing and
// writeback source select codes.
package riscv_pkg;

   localparam int XLEN       = 32;
   localparam int NREG       = 32;
   localparam int REG_ADDR_W = 5;

   localparam logic [1:0] WB_SEL_ALU = 2'b00;
   localparam logic [1:0] WB_SEL_MEM = 2'b01;
   localparam logic [1:0] WB_SEL_PC4 = 2'b10;
   localparam logic [1:0] WB_SEL_IMM = 2'b11;

endpackage

// File: rtl/rb_wb_mux.sv
// Writeback source select for the RB stage, including the JAL/JALR
// link value (PC plus a fixed increment, wrapping mod 2^XLEN).
module rb_wb_mux
   import riscv_pkg::*;
#(
   parameter int W             = 32,
   parameter int RESET_PC_LINK = 4
) (
   input  logic [1:0]   sel,
   input  logic [W-1:0] alu_result,
   input  logic [W-1:0] mem_rdata,
   input  logic [W-1:0] pc,
   input  logic [W-1:0] imm,
   output logic [W-1:0] wb_data
);

   logic [W-1:0] link;

   assign link = pc + W'(RESET_PC_LINK);

   always_comb begin
      wb_data = alu_result;
      unique case (sel)
         WB_SEL_ALU: wb_data = alu_result;
         WB_SEL_MEM: wb_data = mem_rdata;
         WB_SEL_PC4: wb_data = link;
         WB_SEL_IMM: wb_data = imm;
         default:    wb_data = alu_result;
      endcase
   end

endmodule

// File: rtl/rb_writeback_regfile.sv
// Pipeline tail: writeback select, 32x32 register file with
// write-first bypass to the decode read ports, and retire counter.
module rb_writeback_regfile
   import riscv_pkg::*;
#(
   parameter int XLEN          = riscv_pkg::XLEN,
   parameter int NREG          = riscv_pkg::NREG,
   parameter int RESET_PC_LINK = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  valid_RB,
   input  logic [1:0]            PMAItoReg_RB,
   input  logic                  rd_wen_RB,
   input  logic [REG_ADDR_W-1:0] rd_waddr_RB,
   input  logic [XLEN-1:0]       imm_RB,
   input  logic [XLEN-1:0]       mem_rdata_RB,
   input  logic [XLEN-1:0]       alu_result_RB,
   input  logic [XLEN-1:0]       PC_RB,
   input  logic [REG_ADDR_W-1:0] rs1_raddr_D,
   input  logic [REG_ADDR_W-1:0] rs2_raddr_D,
   output logic [XLEN-1:0]       rs1_rdata_D,
   output logic [XLEN-1:0]       rs2_rdata_D,
   output logic [XLEN-1:0]       wb_data_RB,
   output logic                  wb_en_RB,
   output logic [63:0]           instret
);

   logic [XLEN-1:0] regs [NREG];
   logic            byp_en;

   rb_wb_mux #(
      .W             (XLEN),
      .RESET_PC_LINK (RESET_PC_LINK)
   ) u_wb_mux (
      .sel        (PMAItoReg_RB),
      .alu_result (alu_result_RB),
      .mem_rdata  (mem_rdata_RB),
      .pc         (PC_RB),
      .imm        (imm_RB),
      .wb_data    (wb_data_RB)
   );

   assign wb_en_RB = valid_RB & rd_wen_RB & (rd_waddr_RB != '0);

   // While held in reset the array is cleared, so the bypass must not
   // leak an in-flight write onto the read ports either.
   assign byp_en = wb_en_RB & rst_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else if (wb_en_RB) begin
         regs[rd_waddr_RB] <= wb_data_RB;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instret <= '0;
      end else if (valid_RB) begin
         instret <= instret + 64'd1;
      end
   end

   assign rs1_rdata_D =
      (rs1_raddr_D == '0)                     ? '0 :
      (byp_en && rs1_raddr_D == rd_waddr_RB) ? wb_data_RB :
                                                regs[rs1_raddr_D];

   assign rs2_rdata_D =
      (rs2_raddr_D == '0)                     ? '0 :
      (byp_en && rs2_raddr_D == rd_waddr_RB) ? wb_data_RB :
                                                regs[rs2_raddr_D];

endmodule

// File: tb/tb_rb_writeback_regfile.sv
// Bench for rb_writeback_regfile: vector table with a scoreboard queue
// plus hand-written reset sequences.
module tb_rb_writeback_regfile;
   import riscv_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid_RB;
   logic [1:0]  PMAItoReg_RB;
   logic        rd_wen_RB;
   logic [4:0]  rd_waddr_RB;
   logic [31:0] imm_RB, mem_rdata_RB, alu_result_RB, PC_RB;
   logic [4:0]  rs1_raddr_D, rs2_raddr_D;
   logic [31:0] rs1_rdata_D, rs2_rdata_D, wb_data_RB;
   logic        wb_en_RB;
   logic [63:0] instret;

   always #5 clk = ~clk;

   rb_writeback_regfile dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .valid_RB      (valid_RB),
      .PMAItoReg_RB  (PMAItoReg_RB),
      .rd_wen_RB     (rd_wen_RB),
      .rd_waddr_RB   (rd_waddr_RB),
      .imm_RB        (imm_RB),
      .mem_rdata_RB  (mem_rdata_RB),
      .alu_result_RB (alu_result_RB),
      .PC_RB         (PC_RB),
      .rs1_raddr_D   (rs1_raddr_D),
      .rs2_raddr_D   (rs2_raddr_D),
      .rs1_rdata_D   (rs1_rdata_D),
      .rs2_rdata_D   (rs2_rdata_D),
      .wb_data_RB    (wb_data_RB),
      .wb_en_RB      (wb_en_RB),
      .instret       (instret)
   );

   typedef struct {
      logic        v;
      logic [1:0]  sel;
      logic        w;
      logic [4:0]  rd;
      logic [31:0] imm, mem, alu, pc;
      logic [4:0]  r1, r2;
      logic [31:0] e1, e2, ewb;
      logic        een;
   } vec_t;

   typedef struct {
      logic [31:0] e1, e2, ewb;
      logic        een;
      logic [63:0] eir;
   } exp_t;

   vec_t  tbl [13];
   exp_t  sb [$];
   int    passed = 0;
   int    total  = 0;
   longint unsigned ir_model = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic drive(input logic v, input logic [1:0] sel,
                        input logic w, input logic [4:0] rd,
                        input logic [31:0] imm, input logic [31:0] mem,
                        input logic [31:0] alu, input logic [31:0] pc,
                        input logic [4:0] r1, input logic [4:0] r2);
      valid_RB = v; PMAItoReg_RB = sel; rd_wen_RB = w;
      rd_waddr_RB = rd; imm_RB = imm; mem_rdata_RB = mem;
      alu_result_RB = alu; PC_RB = pc;
      rs1_raddr_D = r1; rs2_raddr_D = r2;
   endtask

   initial begin
      exp_t e;
      tbl[0]  = '{1, 0, 1, 5, 0, 0, 32'hDEADBEEF, 0, 5, 0,
                  32'hDEADBEEF, 0, 32'hDEADBEEF, 1};
      tbl[1]  = '{0, 0, 0, 0, 0, 0, 0, 0, 5, 5,
                  32'hDEADBEEF, 32'hDEADBEEF, 0, 0};
      tbl[2]  = '{1, 1, 1, 7, 0, 32'h12345678, 0, 0, 7, 5,
                  32'h12345678, 32'hDEADBEEF, 32'h12345678, 1};
      tbl[3]  = '{1, 2, 1, 7, 0, 0, 0, 32'hFFFFFFFC, 7, 7,
                  0, 0, 0, 1};
      tbl[4]  = '{0, 0, 0, 0, 0, 0, 0, 0, 7, 2, 0, 0, 0, 0};
      tbl[5]  = '{1, 3, 1, 7, 32'hABCDE000, 0, 0, 0, 0, 7,
                  0, 32'hABCDE000, 32'hABCDE000, 1};
      tbl[6]  = '{0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 32'hABCDE000, 0, 0, 0};
      tbl[7]  = '{1, 0, 1, 0, 0, 0, 32'hFFFFFFFF, 0, 0, 0,
                  0, 0, 32'hFFFFFFFF, 0};
      tbl[8]  = '{0, 0, 1, 3, 0, 0, 32'h55, 0, 3, 0, 0, 0, 32'h55, 0};
      tbl[9]  = '{1, 0, 0, 3, 0, 0, 32'h55, 0, 3, 0, 0, 0, 32'h55, 0};
      tbl[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 3, 5, 0, 32'hDEADBEEF, 0, 0};
      tbl[11] = '{1, 2, 1, 31, 0, 0, 0, 32'h00001000, 31, 31,
                  32'h00001004, 32'h00001004, 32'h00001004, 1};
      tbl[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 31, 7,
                  32'h00001004, 32'hABCDE000, 0, 0};

      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int a = 0; a < 32; a++) begin
         rs1_raddr_D = 5'(a);
         rs2_raddr_D = 5'(31 - a);
         #1;
         chk($sformatf("reset_rs1_x%0d", a), rs1_rdata_D, 0);
         chk($sformatf("reset_rs2_x%0d", 31 - a), rs2_rdata_D, 0);
      end
      chk("reset_instret", instret, 0);

      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         drive(tbl[i].v, tbl[i].sel, tbl[i].w, tbl[i].rd, tbl[i].imm,
               tbl[i].mem, tbl[i].alu, tbl[i].pc, tbl[i].r1, tbl[i].r2);
         sb.push_back('{tbl[i].e1, tbl[i].e2, tbl[i].ewb, tbl[i].een,
                        64'(ir_model)});
         if (tbl[i].v) ir_model++;
         #1;
         e = sb.pop_front();
         chk($sformatf("v%0d_rs1", i), rs1_rdata_D, e.e1);
         chk($sformatf("v%0d_rs2", i), rs2_rdata_D, e.e2);
         chk($sformatf("v%0d_wb_data", i), wb_data_RB, e.ewb);
         chk($sformatf("v%0d_wb_en", i), wb_en_RB, e.een);
         chk($sformatf("v%0d_instret", i), instret, e.eir);
      end

      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("final_instret", instret, 64'(ir_model));

      @(negedge clk);
      drive(1, 0, 1, 9, 0, 0, 32'h11, 0, 9, 0);
      @(negedge clk);
      drive(1, 0, 1, 9, 0, 0, 32'h22, 0, 9, 9);
      #1;
      chk("x9_bypass_rs1", rs1_rdata_D, 32'h22);
      chk("x9_bypass_rs2", rs2_rdata_D, 32'h22);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_x9_rs1", rs1_rdata_D, 0);
      chk("rst_x9_rs2", rs2_rdata_D, 0);
      chk("rst_instret", instret, 0);
      @(posedge clk);
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 9, 5);
      rst_n = 1'b1;
      #1;
      chk("post_rst_x9", rs1_rdata_D, 0);
      chk("post_rst_x5", rs2_rdata_D, 0);
      @(negedge clk);
      chk("post_edge_x9", rs1_rdata_D, 0);
      chk("post_edge_instret", instret, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/rb_writeback_regfile.md
Name: rb_writeback_regfile

Overview:
Writeback-end consumer of the M->RB pipeline register. Selects the writeback value from the RB-stage fields and commits it to a 32x32 integer register file (x0 hardwired to zero). Provides two combinational read ports to the decode stage with same-cycle write bypass, plus a 64-bit retired-instruction counter. Sits at the tail of the 5-stage pipeline; its read ports feed the ID stage.

Parameters:
XLEN, 32, datapath and register width
NREG, 32, number of architectural registers (address width = 5)
RESET_PC_LINK, 4, increment added to PC_RB for the link value (JAL/JALR)

Ports:
clk  in  1  core clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
valid_RB  in  1  RB stage holds a real (non-bubble) instruction
PMAItoReg_RB  in  2  writeback source select
rd_wen_RB  in  1  destination write enable
rd_waddr_RB  in  5  destination register index
imm_RB  in  XLEN  immediate (LUI)
mem_rdata_RB  in  XLEN  load data, already extended by the memory stage
alu_result_RB  in  XLEN  ALU result
PC_RB  in  XLEN  instruction PC
rs1_raddr_D  in  5  read port 1 address
rs2_raddr_D  in  5  read port 2 address
rs1_rdata_D  out  XLEN  read port 1 data
rs2_rdata_D  out  XLEN  read port 2 data
wb_data_RB  out  XLEN  selected writeback value (for the forwarding unit)
wb_en_RB  out  1  qualified write strobe (for the forwarding unit)
instret  out  64  retired-instruction count

Behaviour:
- Reset: asynchronous on rst_n low; all 32 registers = 0, instret = 0. Outputs are combinational from this state (read data = 0).
- Source select (combinational): 2'b00 alu_result_RB; 2'b01 mem_rdata_RB; 2'b10 PC_RB + RESET_PC_LINK (mod 2^32, wraps 0xFFFFFFFC -> 0x00000000); 2'b11 imm_RB.
- wb_en_RB = valid_RB & rd_wen_RB & (rd_waddr_RB != 0).
- Write: on a rising clk edge with wb_en_RB = 1, regs[rd_waddr_RB] <= wb_data_RB. Latency 1 cycle to the array; visible on read ports in the same cycle through the bypass.
- x0: never written; reads of address 0 return 0 regardless of the bypass.
- Read ports: combinational. If wb_en_RB and rsN_raddr_D == rd_waddr_RB (nonzero), return wb_data_RB (write-first); else return regs[rsN_raddr_D]. Both ports bypass independently and may hit the same address.
- instret: increments by 1 on every rising edge with valid_RB = 1, independent of rd_wen_RB (stores and branches retire). Wraps at 2^64 - 1 -> 0.
- Bubble (valid_RB = 0): no write, no count, wb_data_RB still driven (don't-care to consumers).
- Reset mid-operation: a pending write in the same cycle as rst_n falling is discarded; the array stays cleared until the first edge after rst_n rises.
- No X propagation: an unknown PMAItoReg_RB value is not possible (all 4 codes defined).

Decomposition:
- Shared package (riscv_pkg): WB_SEL_ALU/MEM/PC4/IMM 2-bit localparams, XLEN, REG_ADDR_W.
- One natural sub-module: rb_wb_mux (4:1 source select + link add), instantiated once. Register array, bypass and counter stay in the top module.

Test Plan:
- Reset: hold rst_n = 0, then release; read all 32 addresses on both ports -> all 0x00000000, instret = 0.
- ALU write + bypass: valid=1, wen=1, rd=5, sel=00, alu=0xDEADBEEF, rs1=5 same cycle -> rs1_rdata_D = 0xDEADBEEF combinationally; next cycle with valid=0 -> still 0xDEADBEEF from array.
- Source select: rd=7 with sel=01 mem=0x12345678 -> x7=0x12345678; sel=10 PC=0xFFFFFFFC -> x7=0x00000000; sel=11 imm=0xABCDE000 -> x7=0xABCDE000.
- x0 protection: valid=1, wen=1, rd=0, alu=0xFFFFFFFF, rs1=rs2=0 -> both read 0, wb_en_RB = 0, instret increments by 1.
- Bubble/no-wen: valid=0, wen=1, rd=3, alu=0x55 -> x3 unchanged, instret unchanged; then valid=1, wen=0 -> x3 unchanged, instret +1.
- Async reset mid-write: set x9=0x11, then assert rst_n low between edges during a write of 0x22 to x9 -> x9 reads 0 immediately; after release x9 stays 0.
